// File: rtl/xfetch.sv
// rtl/xfetch.sv - instruction fetch sequencer in front of a one-cycle-latency program ROM; optional return-address stack under FETCH_CALL_EN
`ifndef PROG_ROM_ADDR_W
`define PROG_ROM_ADDR_W 8
`endif
`ifndef INSTR_W
`define INSTR_W 16
`endif

module xfetch #(
    parameter logic [`PROG_ROM_ADDR_W-1:0] RESET_PC  = '0,
    parameter int                          RAS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [`PROG_ROM_ADDR_W-1:0]   pc,
    input  logic [`INSTR_W-1:0]           rom_instr,
    output logic [`INSTR_W-1:0]           instr,
    output logic [`PROG_ROM_ADDR_W-1:0]   instr_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    input  logic                          redirect,
    input  logic [`PROG_ROM_ADDR_W-1:0]   redirect_addr,
    input  logic                          call,
    input  logic                          ret,
    input  logic                          halt
);

    localparam int AW = `PROG_ROM_ADDR_W;

    if (RAS_DEPTH < 1) begin : g_bad_ras_depth
        $error("xfetch: RAS_DEPTH must be at least 1");
    end

    logic [AW-1:0] r_issued;
    logic          r_req_v;

    logic          w_stall;
    logic          w_fire;
    logic [AW-1:0] w_ret_target;
    logic [AW-1:0] w_link;

    assign w_stall     = r_req_v & ~instr_ready;
    assign w_fire      = r_req_v & instr_ready;
    assign w_link      = r_issued + 1'b1;

    assign instr       = rom_instr;
    assign instr_pc    = r_issued;
    assign instr_valid = r_req_v;

`ifdef FETCH_CALL_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0] r_wp;
    logic [CW-1:0] r_cnt;

    logic [PW-1:0] w_top;
    logic          w_ras_empty;
    logic          w_push;
    logic          w_pop;

    // r_wp is the next slot to write, so the newest entry sits one below it
    assign w_top        = (r_wp == '0) ? PW'(RAS_DEPTH - 1) : r_wp - 1'b1;
    assign w_ras_empty  = (r_cnt == '0);
    assign w_ret_target = w_ras_empty ? redirect_addr : r_ras[w_top];
    assign w_push       = w_fire & call;
    assign w_pop        = w_fire & ret & ~w_ras_empty;

    // Circular stack: a push when full lands on the oldest slot, count saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (w_push && w_pop) begin
            r_ras[w_top] <= w_link;
        end else if (w_push) begin
            r_ras[r_wp] <= w_link;
            r_wp        <= (r_wp == PW'(RAS_DEPTH - 1)) ? '0 : r_wp + 1'b1;
            if (r_cnt != CW'(RAS_DEPTH)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_pop) begin
            r_wp  <= w_top;
            r_cnt <= r_cnt - 1'b1;
        end
    end
`else
    assign w_ret_target = redirect_addr;
`endif

    // Next ROM address; a stall re-reads the same address so the ROM output holds
    always_comb begin
        pc = r_issued;
        if (rst) begin
            pc = RESET_PC;
        end else if (w_stall) begin
            pc = r_issued;
        end else if (w_fire && ret) begin
            pc = w_ret_target;
        end else if (w_fire && (redirect || call)) begin
            pc = redirect_addr;
        end else if (r_req_v) begin
            pc = r_issued + 1'b1;
        end else begin
            pc = r_issued;
        end
    end

    // Track the outstanding fetch; halt only suppresses the valid, the address is kept
    always_ff @(posedge clk) begin
        r_issued <= pc;
        if (rst) begin
            r_req_v <= 1'b0;
        end else if (w_stall) begin
            r_req_v <= 1'b1;
        end else begin
            r_req_v <= ~halt;
        end
    end

endmodule

// File: tb/tb_xfetch.sv
// tb/tb_xfetch.sv - directed-vector bench for xfetch with a registered ROM model
`ifndef PROG_ROM_ADDR_W
`define PROG_ROM_ADDR_W 8
`endif
`ifndef INSTR_W
`define INSTR_W 16
`endif

module tb_xfetch;

    localparam int AW = `PROG_ROM_ADDR_W;
    localparam int IW = `INSTR_W;
    localparam logic [AW-1:0] MAXA = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic [IW-1:0] rom_instr = '0;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          call;
    logic          ret;
    logic          halt;

    int n_vec = 0;
    int n_err = 0;

    xfetch #(.RESET_PC('0), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .rom_instr(rom_instr), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_addr(redirect_addr), .call(call),
        .ret(ret), .halt(halt)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom_f(input logic [AW-1:0] a);
        return IW'(32'(a) * 32'd3 + 32'h1234);
    endfunction

    always @(posedge clk) rom_instr <= rom_f(pc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
        call = 1'b0; ret = 1'b0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_instr_pc", 32'(instr_pc), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);

        rst = 1'b0; #1;
        check("c0_pc", 32'(pc), 32'h0);
        check("c0_valid", 32'(instr_valid), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            check("seq_valid", 32'(instr_valid), 32'h1);
            check("seq_instr_pc", 32'(instr_pc), 32'(k - 1));
            check("seq_pc", 32'(pc), 32'(k));
            check("seq_instr", 32'(instr), 32'(rom_f(AW'(k - 1))));
        end

        repeat (3) next_cycle();
        instr_ready = 1'b0; #1;
        check("stall_pc0", 32'(pc), 32'h5);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            check("stall_instr_pc", 32'(instr_pc), 32'h5);
            check("stall_instr", 32'(instr), 32'(rom_f(AW'(5))));
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_pc", 32'(pc), 32'h5);
        end
        next_cycle();
        instr_ready = 1'b1; #1;
        check("unstall_instr_pc", 32'(instr_pc), 32'h5);
        check("unstall_pc", 32'(pc), 32'h6);
        next_cycle();
        check("unstall_next", 32'(instr_pc), 32'h6);
        check("unstall_valid", 32'(instr_valid), 32'h1);

        rst = 1'b1; #1;
        check("mid_rst_pc", 32'(pc), 32'h0);
        next_cycle();
        rst = 1'b0; #1;
        check("mid_rst_valid", 32'(instr_valid), 32'h0);
        check("mid_rst_instr_pc", 32'(instr_pc), 32'h0);
        repeat (4) next_cycle();
        check("pre_redir_pc", 32'(instr_pc), 32'h3);
        instr_ready = 1'b0; redirect = 1'b1; redirect_addr = AW'(8'h40); #1;
        check("redir_ignored_stall", 32'(pc), 32'h3);
        next_cycle();
        instr_ready = 1'b1; #1;
        check("redir_pc", 32'(pc), 32'h40);
        next_cycle();
        redirect = 1'b0; #1;
        check("redir_instr_pc", 32'(instr_pc), 32'h40);
        check("redir_valid", 32'(instr_valid), 32'h1);
        check("redir_seq_pc", 32'(pc), 32'h41);

        redirect = 1'b1; redirect_addr = MAXA; #1;
        check("wrap_redir_pc", 32'(pc), 32'(MAXA));
        next_cycle();
        redirect = 1'b0; #1;
        check("wrap_instr_pc", 32'(instr_pc), 32'(MAXA));
        check("wrap_pc", 32'(pc), 32'h0);
        next_cycle();
        check("wrap_next", 32'(instr_pc), 32'h0);

        redirect = 1'b1; redirect_addr = AW'(7); #1;
        next_cycle();
        redirect = 1'b0;
        halt = 1'b1; #1;
        check("halt_at_pc", 32'(instr_pc), 32'h7);
        check("halt_pc", 32'(pc), 32'h8);
        next_cycle();
        check("halt_v1", 32'(instr_valid), 32'h0);
        next_cycle();
        halt = 1'b0; #1;
        check("halt_v2", 32'(instr_valid), 32'h0);
        check("halt_resume_pc", 32'(pc), 32'h8);
        next_cycle();
        check("resume_valid", 32'(instr_valid), 32'h1);
        check("resume_instr_pc", 32'(instr_pc), 32'h8);

`ifdef FETCH_CALL_EN
        redirect = 1'b1; redirect_addr = AW'(8'h10); #1;
        next_cycle();
        redirect = 1'b0;
        call = 1'b1; redirect_addr = AW'(8'h80); #1;
        check("call_pc", 32'(pc), 32'h80);
        next_cycle();
        call = 1'b0; #1;
        check("call_t0", 32'(instr_pc), 32'h80);
        next_cycle();
        check("call_t1", 32'(instr_pc), 32'h81);
        next_cycle();
        check("call_t2", 32'(instr_pc), 32'h82);
        ret = 1'b1; redirect_addr = AW'(8'h33); #1;
        check("ret_pc", 32'(pc), 32'h11);
        next_cycle();
        ret = 1'b0; #1;
        check("ret_instr_pc", 32'(instr_pc), 32'h11);

        for (int i = 0; i < 5; i++) begin
            call = 1'b1; redirect_addr = AW'(8'h20 + 8'h10 * i); #1;
            check("nest_call_pc", 32'(pc), 32'(8'h20 + 8'h10 * i));
            next_cycle();
            call = 1'b0;
        end
        begin
            logic [7:0] exp_ret [5];
            exp_ret = '{8'h51, 8'h41, 8'h31, 8'h21, 8'h77};
            for (int i = 0; i < 5; i++) begin
                ret = 1'b1; redirect_addr = AW'(8'h77); #1;
                check("nest_ret_pc", 32'(pc), 32'(exp_ret[i]));
                next_cycle();
                ret = 1'b0; #1;
                check("nest_ret_instr_pc", 32'(instr_pc), 32'(exp_ret[i]));
            end
        end
`else
        ret = 1'b1; redirect_addr = AW'(8'h20); #1;
        check("plain_ret_pc", 32'(pc), 32'h20);
        next_cycle();
        ret = 1'b0; #1;
        check("plain_ret_instr_pc", 32'(instr_pc), 32'h20);
        call = 1'b1; redirect_addr = AW'(8'h30); #1;
        check("plain_call_pc", 32'(pc), 32'h30);
        next_cycle();
        call = 1'b0; #1;
        check("plain_call_instr_pc", 32'(instr_pc), 32'h30);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
